// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART receive sequencer.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_TICKS = 16;
    localparam int unsigned SCNT_W           = 4;

    localparam logic [SCNT_W-1:0] SMP_A    = 4'd7;
    localparam logic [SCNT_W-1:0] SMP_B    = 4'd8;
    localparam logic [SCNT_W-1:0] SMP_C    = 4'd9;
    localparam logic [SCNT_W-1:0] SMP_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // 2-of-3 vote across the mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Byte output handshake plus status pulses from the receive sequencer.
interface uart_rx_sequencer_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO; a push on full is accepted only when a pop frees a slot.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 valid,
    output logic                 overrun
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 full;
    logic                 empty;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign valid   = ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & full & ~do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive bit timing and framing: oversample divider, start detect,
// mid-bit majority sampling, LSB-first assembly and stop check into a FIFO.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic               rxd,
    uart_rx_sequencer_if.master rx,
    output logic               busy,
    output logic [1:0]         rx_state
);

    localparam int unsigned BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_BITS - 1);

    rx_state_e            state;
    rx_state_e            state_n;
    logic                 sync1;
    logic                 sync2;
    logic                 hist;
    logic                 fall;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_last;
    logic                 tick;
    logic [SCNT_W-1:0]    scnt;
    logic                 s7;
    logic                 s7_n;
    logic                 s8;
    logic                 s8_n;
    logic                 vote;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic [BC_W-1:0]      bit_cnt;
    logic [BC_W-1:0]      bit_cnt_n;
    logic                 start_det;
    logic                 push;
    logic                 ferr_n;
    logic                 frame_err_q;

    assign fall     = hist & ~sync2;
    assign div_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick     = (div_cnt == div_last);
    assign vote     = maj3(s7, s8, sync2);
    assign busy     = (state != ST_IDLE);
    assign rx_state = state;
    assign rx.frame_err = frame_err_q;

    // Line synchronizer and edge history; idle-high reset avoids a false start
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            div_cnt     <= '0;
            scnt        <= '0;
            s7          <= 1'b1;
            s8          <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            s7          <= s7_n;
            s8          <= s8_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            frame_err_q <= ferr_n;
            if (start_det) begin
                div_cnt <= '0;
                scnt    <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                scnt    <= (scnt == SCNT_LAST) ? '0 : scnt + SCNT_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        state_n   = state;
        s7_n      = s7;
        s8_n      = s8;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        start_det = 1'b0;
        push      = 1'b0;
        ferr_n    = 1'b0;

        if (tick && scnt == SMP_A) s7_n = sync2;
        if (tick && scnt == SMP_B) s8_n = sync2;

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_n   = ST_START;
                    start_det = 1'b1;
                end
            end
            ST_START: begin
                if (tick && scnt == SMP_C && vote) begin
                    state_n = ST_IDLE;
                end else if (tick && scnt == SCNT_LAST) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (tick && scnt == SMP_C) begin
                    shreg_n = {vote, shreg[DATA_BITS-1:1]};
                end
                if (tick && scnt == SCNT_LAST) begin
                    if (bit_cnt == BIT_LAST) state_n = ST_STOP;
                    else                     bit_cnt_n = bit_cnt + BC_W'(1);
                end
            end
            ST_STOP: begin
                if (tick && scnt == SMP_C) begin
                    state_n = ST_IDLE;
                    push    = vote;
                    ferr_n  = ~vote;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Disable abandons any frame silently
        if (!enable) begin
            state_n   = ST_IDLE;
            start_det = 1'b0;
            push      = 1'b0;
            ferr_n    = 1'b0;
        end
    end

    uart_rx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rx.out_ready),
        .head      (rx.out_data),
        .valid     (rx.out_valid),
        .overrun   (rx.overrun)
    );

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer at baud_div=4 (64 clocks per bit).
module tb_uart_rx_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] baud_div;
    logic        rxd;
    logic        busy;
    logic [1:0]  rx_state;

    uart_rx_sequencer_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_sequencer #(
        .DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .baud_div (baud_div),
        .rxd      (rxd),
        .rx       (rx_if),
        .busy     (busy),
        .rx_state (rx_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;
    int busy_fall_cyc;
    int busy_rises;
    int ferr_pulses, ferr_cycles, ovr_pulses, ovr_cycles;
    logic ferr_prev = 1'b0, ovr_prev = 1'b0, busy_prev = 1'b0;
    logic [7:0] rx_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe pops, status pulses and busy transitions mid-cycle
    always @(negedge clk) begin
        if (rx_if.frame_err) ferr_cycles++;
        if (rx_if.frame_err && !ferr_prev) ferr_pulses++;
        if (rx_if.overrun) ovr_cycles++;
        if (rx_if.overrun && !ovr_prev) ovr_pulses++;
        if (rx_if.out_valid && rx_if.out_ready) rx_q.push_back(rx_if.out_data);
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        if (!busy_prev && busy) busy_rises++;
        ferr_prev = rx_if.frame_err;
        ovr_prev  = rx_if.overrun;
        busy_prev = busy;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        ferr_pulses = 0; ferr_cycles = 0;
        ovr_pulses  = 0; ovr_cycles  = 0;
        busy_rises  = 0; busy_fall_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rxd = 1'b0;
        start_cyc = cyc;
        cycles(64);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(64);
        end
        rxd = stop;
        cycles(64);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; baud_div = 16'd4; rxd = 1'b1;
        rx_if.out_ready = 1'b0;
        cycles(3);
        checks++; if (rx_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_if.out_valid); end
        checks++; if (rx_if.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", rx_if.out_data); end
        checks++; if (rx_if.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b exp=0", rx_if.frame_err); end
        checks++; if (rx_if.overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%0b exp=0", rx_if.overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (rx_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", rx_state); end
        reset = 1'b0;
        cycles(10);
    endtask

    task automatic test_basic();
        clear_obs();
        rx_if.out_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        cycles(40);
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%0h exp=a5", rx_q[0]); end
        end
        checks++; if (ferr_pulses !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", ferr_pulses); end
        checks++; if (ovr_pulses !== 0) begin failures++; $display("FAIL basic_ovr got=%0d exp=0", ovr_pulses); end
        checks++; if (busy_fall_cyc - start_cyc !== 619) begin failures++; $display("FAIL basic_busy_fall got=%0d exp=619", busy_fall_cyc - start_cyc); end
    endtask

    task automatic test_false_start();
        clear_obs();
        @(posedge clk); #1;
        rxd = 1'b0;
        cycles(3);
        checks++; if (rx_state !== 2'd1) begin failures++; $display("FAIL fs_enter got=%0d exp=1", rx_state); end
        cycles(9);
        rxd = 1'b1;
        cycles(30);
        checks++; if (rx_state !== 2'd1) begin failures++; $display("FAIL fs_hold got=%0d exp=1", rx_state); end
        cycles(1);
        checks++; if (rx_state !== 2'd0) begin failures++; $display("FAIL fs_abort got=%0d exp=0", rx_state); end
        cycles(700);
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL fs_push got=%0d exp=0", rx_q.size()); end
        checks++; if (ferr_pulses !== 0) begin failures++; $display("FAIL fs_ferr got=%0d exp=0", ferr_pulses); end
    endtask

    task automatic test_frame_err_break();
        clear_obs();
        send_frame(8'h3C, 1'b0);
        checks++; if (ferr_pulses !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_pulses); end
        checks++; if (ferr_cycles !== 1) begin failures++; $display("FAIL ferr_width got=%0d exp=1", ferr_cycles); end
        checks++; if (rx_if.out_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%0b exp=0", rx_if.out_valid); end
        busy_rises = 0;
        cycles(40 * 64);
        checks++; if (busy_rises !== 0) begin failures++; $display("FAIL break_busy got=%0d exp=0", busy_rises); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL break_push got=%0d exp=0", rx_q.size()); end
        rxd = 1'b1;
        cycles(64);
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        clear_obs();
        rx_if.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        cycles(20);
        checks++; if (ovr_pulses !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_pulses); end
        checks++; if (ovr_cycles !== 1) begin failures++; $display("FAIL ovr_width got=%0d exp=1", ovr_cycles); end
        checks++; if (rx_if.out_data !== 8'h01) begin failures++; $display("FAIL ovr_head got=%0h exp=01", rx_if.out_data); end
        rx_if.out_ready = 1'b1;
        cycles(10);
        checks++; if (rx_q.size() !== 4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            exp_b = 8'(i + 1);
            checks++; if (rx_q[i] !== exp_b) begin failures++; $display("FAIL ovr_order[%0d] got=%0h exp=%0h", i, rx_q[i], exp_b); end
        end
        checks++; if (rx_if.out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%0b exp=0", rx_if.out_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_b;
        clear_obs();
        rx_if.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i * 17), 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk); #1;
                cycles(618);
                rx_if.out_ready = 1'b1;
                cycles(1);
                rx_if.out_ready = 1'b0;
            end
        join
        cycles(10);
        checks++; if (ovr_pulses !== 0) begin failures++; $display("FAIL fp_ovr got=%0d exp=0", ovr_pulses); end
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL fp_one_pop got=%0d exp=1", rx_q.size()); end
        checks++; if (rx_if.out_data !== 8'h22) begin failures++; $display("FAIL fp_head got=%0h exp=22", rx_if.out_data); end
        rx_if.out_ready = 1'b1;
        cycles(10);
        checks++; if (rx_q.size() !== 5) begin failures++; $display("FAIL fp_count got=%0d exp=5", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            exp_b = 8'((i + 1) * 17);
            checks++; if (rx_q[i] !== exp_b) begin failures++; $display("FAIL fp_order[%0d] got=%0h exp=%0h", i, rx_q[i], exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        rx_if.out_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        cycles(20);
        checks++; if (rx_if.out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%0b exp=1", rx_if.out_valid); end
        @(posedge clk); #1;
        rxd = 1'b0;
        cycles(64);
        rxd = 1'b1;
        cycles(140);
        checks++; if (rx_state !== 2'd2) begin failures++; $display("FAIL rm_in_data got=%0d exp=2", rx_state); end
        reset = 1'b1;
        cycles(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", busy); end
        checks++; if (rx_state !== 2'd0) begin failures++; $display("FAIL rm_state got=%0d exp=0", rx_state); end
        checks++; if (rx_if.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", rx_if.out_valid); end
        checks++; if (rx_if.out_data !== 8'h00) begin failures++; $display("FAIL rm_data got=%0h exp=00", rx_if.out_data); end
        reset = 1'b0;
        cycles(700);
        rx_if.out_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        cycles(20);
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL rm_count got=%0d exp=1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0] !== 8'h5A) begin failures++; $display("FAIL rm_byte got=%0h exp=5a", rx_q[0]); end
        end
    endtask

    task automatic test_enable_drop();
        clear_obs();
        rx_if.out_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        @(posedge clk); #1;
        rxd = 1'b0;
        cycles(64);
        rxd = 1'b1;
        cycles(140);
        enable = 1'b0;
        cycles(1);
        checks++; if (rx_state !== 2'd0) begin failures++; $display("FAIL en_state got=%0d exp=0", rx_state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy got=%0b exp=0", busy); end
        checks++; if (rx_if.out_valid !== 1'b1) begin failures++; $display("FAIL en_keep_valid got=%0b exp=1", rx_if.out_valid); end
        checks++; if (rx_if.out_data !== 8'h77) begin failures++; $display("FAIL en_keep_data got=%0h exp=77", rx_if.out_data); end
        cycles(10);
        enable = 1'b1;
        cycles(600);
        checks++; if (ferr_pulses !== 0) begin failures++; $display("FAIL en_ferr got=%0d exp=0", ferr_pulses); end
        rx_if.out_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        cycles(20);
        checks++; if (rx_q.size() !== 2) begin failures++; $display("FAIL en_count got=%0d exp=2", rx_q.size()); end
        if (rx_q.size() == 2) begin
            checks++; if (rx_q[0] !== 8'h77) begin failures++; $display("FAIL en_first got=%0h exp=77", rx_q[0]); end
            checks++; if (rx_q[1] !== 8'h5A) begin failures++; $display("FAIL en_second got=%0h exp=5a", rx_q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err_break();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Bit-timing and framing controller for the UART receive path. It generates the oversample tick from a programmable divisor, detects start bits, and takes 3-sample majority votes at mid-bit. It assembles LSB-first frames, checks the stop bit and buffers completed bytes in a small FIFO with a valid/ready output. It sits between the pad-side `rxd` line and the receive main FSM, which consumes bytes through the handshake.

## Interface

Parameters:
- `DATA_BITS`, 8, data bits per frame (5..8)
- `OVERSAMPLE`, 16, ticks per bit; fixed at 16, sample points depend on it
- `DIV_W`, 16, width of `baud_div`
- `FIFO_DEPTH`, 4, output buffer entries (power of 2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  reset, synchronous, active-high
- `enable`  in  1  receiver enable
- `baud_div`  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
- `rxd`  in  1  asynchronous serial line, idle high
- `out_data`  out  DATA_BITS  FIFO head byte; 0 when empty
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer accepts head
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `overrun`  out  1  one-cycle pulse: good byte dropped, FIFO full
- `busy`  out  1  state != IDLE
- `rx_state`  out  2  current state encoding

## Operation

- `rxd` passes through a 2-flop synchronizer (reset to 1), then a history flop. Falling edge = history 1, synced 0.
- Divider counts 0..baud_div-1 and emits `tick` at terminal count. The divider and sample counter `scnt` (0..15) clear on start detect.
- States:
  - IDLE=0: on falling edge and `enable`, go to START.
  - START=1: at tick with scnt=9, majority of samples 7,8,9 must be 0, else IDLE (false start). At scnt=15 tick, go to DATA with bit_cnt=0.
  - DATA=2: at scnt=9, the majority bit shifts in at the MSB of a right-shift register (LSB first). At scnt=15 with bit_cnt=DATA_BITS-1, go to STOP; otherwise bit_cnt increments.
  - STOP=3: at scnt=9, majority 1 pushes the byte; majority 0 pulses `frame_err` and discards the byte. Both cases return to IDLE immediately. A held-low line (break) does not retrigger, because a new start needs a falling edge.
- FIFO behaviour:
  - A push while full is dropped and pulses `overrun`, unless a pop occurs in the same cycle. In that case both occur and the count is unchanged.
  - A pop occurs on `out_valid & out_ready`.
  - Push and pop on empty: the byte is stored; `out_valid` rises next cycle.
- `enable` low: the next edge forces IDLE and abandons the frame with no push and no error. FIFO contents are retained and can still be popped.
- Reset:
  - state IDLE, counters 0, FIFO empty
  - `out_valid`=0, `out_data`=0, `frame_err`=0, `overrun`=0, `busy`=0, `rx_state`=0
  - synchronizer flops set to 1

## Timing

- Pin fall sampled at edge k: START is entered at edge k+2.
- Bit period = 16·max(baud_div,1) cycles.
- Push occurs on the stop-bit scnt=9 tick: (1+DATA_BITS)·16+10 ticks after start detect. `out_valid`/`out_data` update on the following edge.
- `frame_err`/`overrun` assert on the edge after the stop-bit decision and last exactly one cycle.
- Pop: the next head appears on the edge after `out_valid & out_ready`.
- Next frame: a start edge is accepted from the first cycle back in IDLE. Stop-to-start slack is 6 ticks.

## Structure

- `uart_pkg`: state encodings, OVERSAMPLE=16, sample-point constants 7/8/9/15, majority function.
- Sub-module `uart_rx_fifo`: synchronous FIFO with count, push/pop, full/empty, simultaneous push/pop on full. All else lives in `uart_rx_sequencer`.

## Test plan

- baud_div=4, `out_ready`=1, send 0xA5 with stop=1 -> single `out_valid` with `out_data`=0xA5, no error pulses, `busy` falls at stop scnt=9.
- `rxd` low for 3 ticks then high -> START then IDLE at scnt=9, no push, no `frame_err`.
- Send 0x3C with stop=0 -> one-cycle `frame_err`, FIFO empty. Line held low 40 bit-times -> no further activity until high-then-low.
- `out_ready`=0, send 0x01..0x05 -> 4 bytes stored, `overrun` pulse on 0x05. Then `out_ready`=1 -> 0x01,0x02,0x03,0x04 in order.
- FIFO full, `out_ready` asserted on the push cycle of a fifth byte -> no `overrun`, count stays 4, fifth byte is delivered last.
- Reset asserted mid-DATA, or `enable` dropped mid-frame -> next edge IDLE with all outputs at reset values. Reset also clears the FIFO; `enable` keeps it. A following 0x5A is received correctly.
